// File: rtl/report_tx_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the outbound report link.
package report_tx_pkg;

  localparam logic [1:0] ID_AIRFLOW   = 2'b00;
  localparam logic [1:0] ID_THRUSTERS = 2'b01;
  localparam logic [1:0] ID_SOLAR     = 2'b10;

  localparam logic [7:0] OP_BIN  = 8'h62;
  localparam logic [7:0] OP_FLT  = 8'h66;
  localparam logic [7:0] EOL     = 8'h0A;
  localparam logic [7:0] ID_BASE = 8'h30;

  localparam int FRAME_LEN = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ID   = 3'd2,
    S_IDX  = 3'd3,
    S_VAL  = 3'd4,
    S_EOL  = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        kind;
    logic [7:0]  index;
    logic [63:0] value;
  } entry_t;

  function automatic logic [7:0] opcode_of(input logic kind);
    return kind ? OP_FLT : OP_BIN;
  endfunction

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO for pending reports; wrap is tracked by one extra pointer MSB.
module report_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);

endmodule

// File: rtl/report_tx.sv
// Round-robin report arbiter, pending FIFO and 12-byte frame serialiser towards the stdout bridge.
module report_tx
  import report_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int VW    = 64,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_valid,
  input  logic [2:0]      req_kind,
  input  logic [23:0]     req_index,
  input  logic [3*VW-1:0] req_value,
  output logic [2:0]      req_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic [CNTW-1:0] frames_sent
);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  entry_t          cur_q, cur_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [CNTW-1:0] frames_q, frames_d;
  logic [1:0]      rr_q, rr_d;
  logic [2:0]      grant_s;
  logic            push_s, pop_s, hs_s;
  logic            fifo_full_s, fifo_empty_s;
  entry_t          push_entry_s, fifo_dout_s;

  // First requester at or after the round-robin pointer.
  always_comb begin
    grant_s = 3'b000;
    case (rr_q)
      2'd0: begin
        if (req_valid[0]) grant_s = 3'b001;
        else if (req_valid[1]) grant_s = 3'b010;
        else if (req_valid[2]) grant_s = 3'b100;
        else grant_s = 3'b000;
      end
      2'd1: begin
        if (req_valid[1]) grant_s = 3'b010;
        else if (req_valid[2]) grant_s = 3'b100;
        else if (req_valid[0]) grant_s = 3'b001;
        else grant_s = 3'b000;
      end
      2'd2: begin
        if (req_valid[2]) grant_s = 3'b100;
        else if (req_valid[0]) grant_s = 3'b001;
        else if (req_valid[1]) grant_s = 3'b010;
        else grant_s = 3'b000;
      end
      default: grant_s = 3'b000;
    endcase
  end

  // Full is taken before any same-cycle pop, so a freeing EOL pop cannot admit a push.
  assign req_ready = (rst && !fifo_full_s) ? grant_s : 3'b000;
  assign push_s    = |req_ready;

  // Entry and next pointer for the granted source.
  always_comb begin
    push_entry_s = '0;
    rr_d         = rr_q;
    case (req_ready)
      3'b001: begin
        push_entry_s = '{id: ID_AIRFLOW, kind: req_kind[0], index: req_index[7:0],
                         value: req_value[63:0]};
        rr_d = 2'd1;
      end
      3'b010: begin
        push_entry_s = '{id: ID_THRUSTERS, kind: req_kind[1], index: req_index[15:8],
                         value: req_value[127:64]};
        rr_d = 2'd2;
      end
      3'b100: begin
        push_entry_s = '{id: ID_SOLAR, kind: req_kind[2], index: req_index[23:16],
                         value: req_value[191:128]};
        rr_d = 2'd0;
      end
      default: begin
        push_entry_s = '0;
        rr_d         = rr_q;
      end
    endcase
  end

  report_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (push_entry_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign hs_s = tx_valid_q && tx_ready;

  // Frame FSM: each output register holds the byte to present after the coming edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    frames_d   = frames_q;
    pop_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          cur_d      = fifo_dout_s;
          tx_data_d  = opcode_of(fifo_dout_s.kind);
          tx_valid_d = 1'b1;
          state_d    = S_HDR;
        end else begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
        end
      end
      S_HDR: begin
        if (hs_s) begin
          tx_data_d = ID_BASE + {6'd0, cur_q.id};
          state_d   = S_ID;
        end else begin
          state_d = S_HDR;
        end
      end
      S_ID: begin
        if (hs_s) begin
          tx_data_d = cur_q.index;
          state_d   = S_IDX;
        end else begin
          state_d = S_ID;
        end
      end
      S_IDX: begin
        if (hs_s) begin
          tx_data_d   = cur_q.value[63:56];
          cur_d.value = {cur_q.value[55:0], 8'h00};
          cnt_d       = 3'd0;
          state_d     = S_VAL;
        end else begin
          state_d = S_IDX;
        end
      end
      S_VAL: begin
        if (hs_s && (cnt_q == 3'd7)) begin
          tx_data_d = EOL;
          state_d   = S_EOL;
        end else if (hs_s) begin
          tx_data_d   = cur_q.value[63:56];
          cur_d.value = {cur_q.value[55:0], 8'h00};
          cnt_d       = cnt_q + 3'd1;
        end else begin
          state_d = S_VAL;
        end
      end
      S_EOL: begin
        if (hs_s && !fifo_empty_s) begin
          frames_d  = frames_q + CNTW'(1);
          pop_s     = 1'b1;
          cur_d     = fifo_dout_s;
          tx_data_d = opcode_of(fifo_dout_s.kind);
          state_d   = S_HDR;
        end else if (hs_s) begin
          frames_d   = frames_q + CNTW'(1);
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_EOL;
        end
      end
      default: begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State, shifter, output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      cur_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      frames_q   <= '0;
      rr_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frames_q   <= frames_d;
      rr_q       <= rr_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign frames_sent = frames_q;
  assign busy        = !fifo_empty_s || (state_q != S_IDLE);

endmodule

// File: tb/tb_report_tx.sv
// Self-checking bench for report_tx: directed vector table, corner sequences and a random run scored against a frame model.
module tb_report_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   req_valid = 3'b000;
  logic [2:0]   req_kind = 3'b000;
  logic [23:0]  req_index = 24'h0;
  logic [191:0] req_value = '0;
  logic         tx_ready = 1'b0;
  logic [2:0]   req_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic [15:0]  frames_sent;

  int checks = 0;
  int failures = 0;

  report_tx #(.DEPTH(4), .VW(64), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kind(req_kind),
    .req_index(req_index), .req_value(req_value), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] frame_of(input int id, input logic kind,
                                           input logic [7:0] idx, input logic [63:0] val);
    logic [7:0] id8;
    id8 = 8'h30 + 8'(id);
    return {(kind ? 8'h66 : 8'h62), id8, idx, val, 8'h0A};
  endfunction

  // Reference model: accepted reports become expected bytes; occupancy = accepted - completed.
  logic [7:0]  exp_q[$];
  int          held = 0, completed = 0, bytes_in = 0, m_ptr = 0;
  int          mon_g, mon_eg;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [95:0] mon_f;
  logic [7:0]  mon_b;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      held = 0; completed = 0; bytes_in = 0; m_ptr = 0; prev_stall = 1'b0;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frames", frames_sent, 16'h0);
      chk("rst_req_ready", req_ready, 3'b000);
    end else begin
      chk("busy", busy, held > 0);
      chk("frames_sent", frames_sent, 16'(completed));
      chk("grant_subset", req_ready & ~req_valid, 3'b000);
      mon_eg = -1;
      for (int off = 0; off < 3; off++) begin
        if (mon_eg < 0 && req_valid[(m_ptr + off) % 3]) mon_eg = (m_ptr + off) % 3;
      end
      if (req_ready != 3'b000 && mon_eg >= 0) chk("grant_rr", req_ready, 3'b001 << mon_eg);
      else if (req_valid != 3'b000 && held < 4) chk("grant_missing", req_ready, 3'b001 << mon_eg);
      if (held >= 5) chk("grant_when_full", req_ready, 3'b000);
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1'b1);
        chk("stall_data", tx_data, prev_data);
      end
      if ((req_valid & req_ready) != 3'b000) begin
        mon_g = req_ready[0] ? 0 : (req_ready[1] ? 1 : 2);
        mon_f = frame_of(mon_g, req_kind[mon_g], req_index[8*mon_g +: 8], req_value[64*mon_g +: 64]);
        for (int k = 0; k < 12; k++) exp_q.push_back(mon_f[95-8*k -: 8]);
        held++;
        m_ptr = (mon_g + 1) % 3;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte actual=%0h required=no byte", tx_data);
        end else begin
          mon_b = exp_q.pop_front();
          chk("stream_byte", tx_data, mon_b);
          bytes_in++;
          if (bytes_in == 12) begin
            bytes_in = 0; completed++; held--;
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic send(input int src, input logic kind, input logic [7:0] idx,
                      input logic [63:0] val, input int budget, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_kind[src] = kind;
    req_index[8*src +: 8] = idx;
    req_value[64*src +: 64] = val;
    req_valid[src] = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_ready[src]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[src] = 1'b0;
  endtask

  task automatic collect(input logic [95:0] exp, input int stall_at, input int stall_len,
                         input string tag);
    int got = 0, stalled = 0, cyc = 0, first = -1, last = -1;
    while (got < 12 && cyc < 400) begin
      @(posedge clk); #1;
      if (got == stall_at && stalled < stall_len) begin
        tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) begin
        chk({tag, "_byte"}, tx_data, exp[95-8*got -: 8]);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    chk({tag, "_handshakes"}, got, 12);
    if (stall_len == 0) chk({tag, "_consecutive"}, last - first, 11);
    @(negedge clk);
    chk({tag, "_busy_falls"}, busy, 1'b0);
    chk({tag, "_valid_falls"}, tx_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frames", frames_sent, 16'h0);
    chk("mid_rst_req_ready", req_ready, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    int          src;
    logic        kind;
    logic [7:0]  idx;
    logic [63:0] val;
    int          stall_at;
    int          stall_len;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs[4];
  bit   ok;
  int   n, seen, gaps, waitn, hs;
  logic [7:0] tri_bytes[36];
  logic [2:0] g;

  initial begin
    vecs[0] = '{2, 1'b1, 8'h01, 64'h405E000000000000, -1, 0, 96'h66_32_01_40_5E_00_00_00_00_00_00_0A};
    vecs[1] = '{0, 1'b0, 8'h05, 64'h0000000000000001, 6, 5, 96'h62_30_05_00_00_00_00_00_00_00_01_0A};
    vecs[2] = '{1, 1'b0, 8'hA7, 64'h0123456789ABCDEF, 0, 3, 96'h62_31_A7_01_23_45_67_89_AB_CD_EF_0A};
    vecs[3] = '{1, 1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 11, 2, 96'h66_31_FF_FF_FF_FF_FF_FF_FF_FF_FF_0A};

    req_valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 3'b000;
    rst = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      fork
        send(vecs[v].src, vecs[v].kind, vecs[v].idx, vecs[v].val, 20, ok);
        collect(vecs[v].exp, vecs[v].stall_at, vecs[v].stall_len, $sformatf("vec%0d", v));
      join
      chk("vec_granted", ok, 1'b1);
      chk("vec_frames", frames_sent, 16'(v + 1));
    end

    // All three request in the first cycle after reset.
    do_reset();
    req_kind = 3'b010;
    req_index = 24'h33_22_11;
    req_value = {64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    req_valid = 3'b111;
    tx_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("tri_grant", req_ready, 3'b001 << k);
          @(posedge clk); #1;
          req_valid[k] = 1'b0;
        end
      end
      begin
        waitn = 0;
        @(negedge clk);
        while (!tx_valid && waitn < 20) begin
          @(negedge clk);
          waitn++;
        end
        gaps = 0;
        for (int i = 0; i < 36; i++) begin
          if (!(tx_valid && tx_ready)) gaps++;
          tri_bytes[i] = tx_data;
          @(negedge clk);
        end
        chk("tri_gaps", gaps, 0);
        chk("tri_id0", tri_bytes[1], 8'h30);
        chk("tri_id1", tri_bytes[13], 8'h31);
        chk("tri_id2", tri_bytes[25], 8'h32);
        chk("tri_idle_after", tx_valid, 1'b0);
      end
    join
    chk("tri_frames", frames_sent, 16'd3);

    // Capacity with the sink stalled: 1 in the shifter plus 4 queued.
    tx_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      send(1, 1'b0, 8'(r), 64'hC0DE_0000_0000_0000 + 64'(r), 4, ok);
      chk("cap_accept", ok, 1'b1);
    end
    @(posedge clk); #1;
    req_kind[1] = 1'b1;
    req_index[15:8] = 8'h55;
    req_value[127:64] = 64'hC0DE_0000_0000_0005;
    req_valid[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[1]) seen++;
    end
    chk("cap_sixth_blocked", seen, 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cap_grant_after_eol", n, 12);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    send(1, 1'b0, 8'h66, 64'hC0DE_0000_0000_0006, 40, ok);
    chk("cap_seventh", ok, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cap_drain", busy, 1'b0);
    chk("cap_frames", frames_sent, 16'd10);

    // Reset after byte 4 with two entries queued, then a fresh frame.
    tx_ready = 1'b0;
    send(0, 1'b1, 8'h10, 64'h1111_2222_3333_4444, 4, ok);
    send(1, 1'b0, 8'h20, 64'h5555_6666_7777_8888, 4, ok);
    send(2, 1'b1, 8'h30, 64'h9999_AAAA_BBBB_CCCC, 4, ok);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    hs = 0;
    n = 0;
    while (hs < 5 && n < 40) begin
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
      n++;
    end
    chk("mid_bytes_before_rst", hs, 5);
    do_reset();
    fork
      send(vecs[0].src, vecs[0].kind, vecs[0].idx, vecs[0].val, 20, ok);
      collect(vecs[0].exp, -1, 0, "post_rst");
    join
    chk("post_rst_frames", frames_sent, 16'd1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_kind[i] = 1'($urandom_range(1));
          req_index[8*i +: 8] = 8'($urandom);
          req_value[64*i +: 64] = {$urandom, $urandom};
          req_valid[i] = 1'b1;
        end
      end
      tx_ready = ($urandom_range(3) != 0);
    end
    tx_ready = 1'b1;
    n = 0;
    while (req_valid != 3'b000 && n < 300) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      n++;
    end
    chk("rand_requests_drained", req_valid, 3'b000);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rand_busy_drained", busy, 1'b0);
    chk("rand_all_bytes_out", exp_q.size(), 0);
    chk("rand_frames", frames_sent, 16'(completed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
